// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: decoder control bundle, opcodes and halt FSM states.
package riscv_pkg;

  // Field order mirrors the decoder outputs; halt is the MSB.
  typedef struct packed {
    logic       halt;
    logic       alu_src;
    logic       jalto_reg;
    logic       memto_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       branch;
    logic       jalr_sel;
  } ctrl_t;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_U    = 7'b0110111;
  localparam logic [6:0] OPC_LW   = 7'b0000011;
  localparam logic [6:0] OPC_SW   = 7'b0100011;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_HALT = 7'b1111111;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard check between the load in EX and the source registers read in ID.
module hazard_detect (
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       hz
);

  // rs2 is compared for every format, so an occasional spurious stall is accepted.
  assign hz = ex_mem_read && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles and the halt drain sequence.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  ctrl_t           id_ctrl,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rd1,
  input  logic [XLEN-1:0] id_rd2,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [2:0]      id_funct3,
  input  logic [6:0]      id_funct7,
  input  logic            flush,
  output ctrl_t           ex_ctrl,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rd1,
  output logic [XLEN-1:0] ex_rd2,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct7,
  output logic            stall,
  output logic            halted
);

  localparam int unsigned CntW = $clog2(DRAIN_CYCLES + 1);

  ctrl_t            r_ex_ctrl;
  logic [XLEN-1:0]  r_ex_pc, r_ex_rd1, r_ex_rd2, r_ex_imm;
  logic [4:0]       r_ex_rs1, r_ex_rs2, r_ex_rd;
  logic [2:0]       r_ex_funct3;
  logic [6:0]       r_ex_funct7;
  halt_state_t      r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic             r_halted;

  logic w_hz_raw, w_hz, w_run, w_bubble, w_load_halt;

  hazard_detect u_hazard_detect (
    .ex_mem_read (r_ex_ctrl.mem_read),
    .ex_rd       (r_ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .hz          (w_hz_raw)
  );

  // Flush outranks the hazard, so a squashed instruction never stalls the front end.
  assign w_run       = (r_state == RUN);
  assign w_hz        = w_hz_raw & ~flush;
  assign stall       = ~w_run | w_hz;
  assign w_bubble    = flush | w_hz | ~w_run;
  assign w_load_halt = w_run & ~flush & ~w_hz_raw & id_ctrl.halt;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      RUN: begin
        if (w_load_halt) begin
          w_state_d = DRAIN;
          w_cnt_d   = CntW'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        if (r_cnt == '0) begin
          w_state_d = HALTED;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      HALTED:  w_state_d = HALTED;
      default: w_state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= RUN;
      r_cnt    <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_halted <= (w_state_d == HALTED);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ex_ctrl   <= '0;
      r_ex_pc     <= '0;
      r_ex_rd1    <= '0;
      r_ex_rd2    <= '0;
      r_ex_imm    <= '0;
      r_ex_rs1    <= '0;
      r_ex_rs2    <= '0;
      r_ex_rd     <= '0;
      r_ex_funct3 <= '0;
      r_ex_funct7 <= '0;
    end else begin
      r_ex_ctrl   <= w_bubble ? '0 : id_ctrl;
      r_ex_pc     <= id_pc;
      r_ex_rd1    <= id_rd1;
      r_ex_rd2    <= id_rd2;
      r_ex_imm    <= id_imm;
      r_ex_rs1    <= id_rs1;
      r_ex_rs2    <= id_rs2;
      r_ex_rd     <= id_rd;
      r_ex_funct3 <= id_funct3;
      r_ex_funct7 <= id_funct7;
    end
  end

  assign ex_ctrl   = r_ex_ctrl;
  assign ex_pc     = r_ex_pc;
  assign ex_rd1    = r_ex_rd1;
  assign ex_rd2    = r_ex_rd2;
  assign ex_imm    = r_ex_imm;
  assign ex_rs1    = r_ex_rs1;
  assign ex_rs2    = r_ex_rs2;
  assign ex_rd     = r_ex_rd;
  assign ex_funct3 = r_ex_funct3;
  assign ex_funct7 = r_ex_funct7;
  assign halted    = r_halted;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for pipelining/hazards, hand sequences for halt and reset.
module tb_id_ex_stage;
  import riscv_pkg::*;

  // {halt,alu_src,jalto_reg,memto_reg,reg_write,mem_read,mem_write,alu_op[1:0],branch,jalr_sel}
  localparam logic [10:0] C_ADD  = 11'b0_0_0_0_1_0_0_10_0_0;
  localparam logic [10:0] C_LW   = 11'b0_1_0_1_1_1_0_00_0_0;
  localparam logic [10:0] C_SW   = 11'b0_1_0_0_0_0_1_00_0_0;
  localparam logic [10:0] C_HALT = 11'b1_0_0_0_0_0_0_00_0_0;
  localparam logic [10:0] C_NOP  = 11'b0;

  logic        clk, reset_n, flush;
  ctrl_t       id_ctrl, ex_ctrl;
  logic [31:0] id_pc, id_rd1, id_rd2, id_imm, ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  id_funct3, ex_funct3;
  logic [6:0]  id_funct7, ex_funct7;
  logic        stall, halted;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(
    .XLEN         (32),
    .DRAIN_CYCLES (3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .id_ctrl   (id_ctrl),
    .id_pc     (id_pc),
    .id_rd1    (id_rd1),
    .id_rd2    (id_rd2),
    .id_imm    (id_imm),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .id_rd     (id_rd),
    .id_funct3 (id_funct3),
    .id_funct7 (id_funct7),
    .flush     (flush),
    .ex_ctrl   (ex_ctrl),
    .ex_pc     (ex_pc),
    .ex_rd1    (ex_rd1),
    .ex_rd2    (ex_rd2),
    .ex_imm    (ex_imm),
    .ex_rs1    (ex_rs1),
    .ex_rs2    (ex_rs2),
    .ex_rd     (ex_rd),
    .ex_funct3 (ex_funct3),
    .ex_funct7 (ex_funct7),
    .stall     (stall),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] ctrl;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        fl;
    logic        exp_stall;
    logic [10:0] exp_ctrl;
    logic        chk_data;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [10:0] c, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] pc, input logic fl);
    id_ctrl   = ctrl_t'(c);
    id_rs1    = rs1;
    id_rs2    = rs2;
    id_rd     = rd;
    id_pc     = pc;
    id_rd1    = pc + 32'd1;
    id_rd2    = pc + 32'd2;
    id_imm    = pc + 32'd3;
    id_funct3 = pc[2:0];
    id_funct7 = pc[6:0];
    flush     = fl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{C_ADD, 5'd1,  5'd2,  5'd3,  32'h100, 1'b0, 1'b0, C_ADD, 1'b1};
    vecs[1]  = '{C_LW,  5'd3,  5'd0,  5'd5,  32'h104, 1'b0, 1'b0, C_LW,  1'b1};
    vecs[2]  = '{C_ADD, 5'd5,  5'd1,  5'd6,  32'h108, 1'b0, 1'b1, C_NOP, 1'b0};
    vecs[3]  = '{C_ADD, 5'd5,  5'd1,  5'd6,  32'h108, 1'b0, 1'b0, C_ADD, 1'b1};
    vecs[4]  = '{C_LW,  5'd1,  5'd0,  5'd0,  32'h10c, 1'b0, 1'b0, C_LW,  1'b1};
    vecs[5]  = '{C_ADD, 5'd0,  5'd0,  5'd7,  32'h110, 1'b0, 1'b0, C_ADD, 1'b1};
    vecs[6]  = '{C_LW,  5'd2,  5'd0,  5'd8,  32'h114, 1'b0, 1'b0, C_LW,  1'b1};
    vecs[7]  = '{C_ADD, 5'd8,  5'd8,  5'd9,  32'h118, 1'b1, 1'b0, C_NOP, 1'b0};
    vecs[8]  = '{C_SW,  5'd8,  5'd9,  5'd0,  32'h200, 1'b0, 1'b0, C_SW,  1'b1};
    vecs[9]  = '{C_LW,  5'd4,  5'd0,  5'd10, 32'h204, 1'b0, 1'b0, C_LW,  1'b1};
    vecs[10] = '{C_SW,  5'd1,  5'd10, 5'd0,  32'h208, 1'b0, 1'b1, C_NOP, 1'b0};
    vecs[11] = '{C_SW,  5'd1,  5'd10, 5'd0,  32'h208, 1'b0, 1'b0, C_SW,  1'b1};

    reset_n = 1'b0;
    drive(C_ADD, 5'd1, 5'd2, 5'd3, 32'h100, 1'b0);
    #3 reset_n = 1'b1;
    #1;
    chk("reset_ex_ctrl", 32'(ex_ctrl), 32'(C_NOP));
    chk("reset_ex_rd", 32'(ex_rd), 32'd0);
    chk("reset_ex_pc", ex_pc, 32'd0);
    chk("reset_ex_imm", ex_imm, 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].ctrl, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].pc, vecs[i].fl);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
      tick();
      chk($sformatf("v%0d_ctrl", i), 32'(ex_ctrl), 32'(vecs[i].exp_ctrl));
      if (vecs[i].chk_data) begin
        chk($sformatf("v%0d_rd", i), 32'(ex_rd), 32'(vecs[i].rd));
        chk($sformatf("v%0d_rs1", i), 32'(ex_rs1), 32'(vecs[i].rs1));
        chk($sformatf("v%0d_pc", i), ex_pc, vecs[i].pc);
        chk($sformatf("v%0d_imm", i), ex_imm, vecs[i].pc + 32'd3);
      end
    end

    // Halt squashed by flush must leave the core running.
    drive(C_HALT, 5'd0, 5'd0, 5'd0, 32'h300, 1'b1);
    #1;
    chk("hflush_stall_pre", 32'(stall), 32'd0);
    tick();
    chk("hflush_ctrl", 32'(ex_ctrl), 32'(C_NOP));
    chk("hflush_stall", 32'(stall), 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(C_ADD, 5'(i), 5'(i + 1), 5'(i + 2), 32'h304 + 32'(i), 1'b0);
      tick();
      chk($sformatf("hflush_run%0d_halted", i), 32'(halted), 32'd0);
      chk($sformatf("hflush_run%0d_stall", i), 32'(stall), 32'd0);
    end

    // Real halt: stall from the load edge, halted exactly three edges later.
    drive(C_HALT, 5'd0, 5'd0, 5'd0, 32'h400, 1'b0);
    #1;
    chk("halt_stall_pre", 32'(stall), 32'd0);
    tick();
    chk("halt_load_ctrl", 32'(ex_ctrl), 32'(C_HALT));
    chk("halt_load_stall", 32'(stall), 32'd1);
    chk("halt_load_halted", 32'(halted), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      drive(C_ADD, 5'(k), 5'(k + 3), 5'(k + 7), 32'h404 + 32'(k), (k == 2));
      tick();
      chk($sformatf("drain%0d_ctrl", k), 32'(ex_ctrl), 32'(C_NOP));
      chk($sformatf("drain%0d_stall", k), 32'(stall), 32'd1);
      chk($sformatf("drain%0d_halted", k), 32'(halted), 32'(k == 3));
    end
    for (int k = 0; k < 3; k++) begin
      drive(C_LW, 5'(k + 1), 5'(k + 2), 5'(k + 20), 32'h500 + 32'(k), 1'b0);
      tick();
      chk($sformatf("hold%0d_halted", k), 32'(halted), 32'd1);
      chk($sformatf("hold%0d_stall", k), 32'(stall), 32'd1);
      chk($sformatf("hold%0d_ctrl", k), 32'(ex_ctrl), 32'(C_NOP));
    end

    // Reset out of HALTED between edges.
    drive(C_ADD, 5'd1, 5'd2, 5'd3, 32'h600, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("rst_halted_halted", 32'(halted), 32'd0);
    chk("rst_halted_stall", 32'(stall), 32'd0);
    #1 reset_n = 1'b1;

    // Reset mid-DRAIN, asynchronously.
    drive(C_HALT, 5'd0, 5'd0, 5'd0, 32'h700, 1'b0);
    tick();
    chk("drain2_load_stall", 32'(stall), 32'd1);
    drive(C_ADD, 5'd1, 5'd2, 5'd3, 32'h704, 1'b0);
    tick();
    chk("drain2_stall", 32'(stall), 32'd1);
    chk("drain2_halted", 32'(halted), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_ctrl", 32'(ex_ctrl), 32'(C_NOP));
    chk("async_rst_halted", 32'(halted), 32'd0);
    chk("async_rst_stall", 32'(stall), 32'd0);
    chk("async_rst_pc", ex_pc, 32'd0);
    #1 reset_n = 1'b1;
    drive(C_ADD, 5'd1, 5'd2, 5'd4, 32'h800, 1'b0);
    tick();
    chk("post_rst_ctrl", 32'(ex_ctrl), 32'(C_ADD));
    chk("post_rst_rd", 32'(ex_rd), 32'd4);
    chk("post_rst_stall", 32'(stall), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_rst%0d_halted", i), 32'(halted), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage RISC-V core, directly downstream of the opcode decoder. It captures the decoder's control bundle, the decode-stage operands and the register indices, and presents them registered to EX. It owns load-use hazard detection (stall plus bubble), branch flush squashing, and the halt drain sequence that freezes the core once a halt opcode reaches writeback.

## Interface
- XLEN, 32: datapath width.
- DRAIN_CYCLES, 3: cycles after halt enters EX before `halted` asserts (EX, MEM, WB).
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- id_ctrl  in  ctrl_t  decoder bundle: halt, alu_src, jalto_reg, memto_reg, reg_write, mem_read, mem_write, alu_op[1:0], branch, jalr_sel.
- id_pc, id_rd1, id_rd2, id_imm  in  XLEN each  PC, register read data, immediate.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_funct3  in  3; id_funct7  in  7  ALU-control fields.
- flush  in  1  branch/jump taken in EX; kill the ID instruction.
- ex_ctrl  out  ctrl_t; ex_pc, ex_rd1, ex_rd2, ex_imm  out  XLEN; ex_rs1, ex_rs2, ex_rd  out  5; ex_funct3  out  3; ex_funct7  out  7  registered stage outputs.
- stall  out  1  combinational; hold PC and IF/ID.
- halted  out  1  registered; core frozen.

## Operation
- Load-use hazard: `hz = ex_ctrl.mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2)`.
  - The check is conservative. The rs2 field is compared even for formats without rs2, so a spurious single-cycle stall is legal.
- Per-edge update priority:
  1. flush: ex_ctrl <= 0 (bubble). Data fields are don't-care and are loaded from ID. stall = 0.
  2. hz: ex_ctrl <= 0, stall = 1. IF/ID holds, so the same instruction is re-presented next cycle.
  3. Otherwise, all ex_* load from id_*.
- A bubble means every ctrl_t bit is 0. In particular, reg_write, mem_write, branch and halt are 0.
- Halt FSM, state halt_state_t:
  - RUN -> DRAIN when id_ctrl.halt is loaded into EX, i.e. not flushed and not stalled. A down-counter is loaded with DRAIN_CYCLES-1.
  - DRAIN: the counter decrements each cycle. At 0 the next state is HALTED. stall = 1 throughout DRAIN, and ex_ctrl <= 0 after the halt leaves EX. Younger instructions are never issued.
  - HALTED: halted = 1, stall = 1, ex_ctrl held at 0. Only reset exits this state.
- A halt squashed by flush does not leave RUN.
- Flush in DRAIN/HALTED is ignored for the FSM. It still forces a bubble.
- Reset (async, any state): all ex_* = 0, state RUN, counter 0, halted = 0. stall = 0 because ex_ctrl = 0. Reset mid-DRAIN returns to RUN immediately.

## Timing
- Latency: one cycle from id_* to ex_*.
- stall is combinational from registered ex_ctrl/ex_rd and the live id_rs1/id_rs2. It has no combinational path from flush except through the priority gate.
- A load-use hazard costs exactly one stall cycle. On the next cycle ex_ctrl is a bubble, so hz = 0.
- Halt is loaded into EX at edge N.
  - DRAIN begins in cycle N.
  - halted rises after edge N+DRAIN_CYCLES.
  - stall is 1 from cycle N onward.

## Structure
- Shared package riscv_pkg holds:
  - ctrl_t packed struct, with field order matching the decoder outputs;
  - the opcode constants (R, I, U, LW, SW, BR, JAL, JALR, HALT = 7'b1111111);
  - halt_state_t enum {RUN, DRAIN, HALTED}.
- Sub-module hazard_detect: purely combinational computation of hz from ex_mem_read, ex_rd, id_rs1, id_rs2.
- Everything else stays in id_ex_stage: pipeline registers, priority mux, halt FSM and counter.

## Test plan
- Reset is released with id_ctrl = add x3,x1,x2.
  - Required: all ex_* are 0 before the first edge.
  - After the first edge: ex_ctrl.reg_write = 1, ex_ctrl.alu_op = 2'b10, ex_rd = 3, stall = 0.
- lw x5 is in EX; ID presents add x6,x5,x1.
  - Required: stall = 1 for one cycle, the next ex_ctrl is all-zero, and the following edge loads the add with ex_rs1 = 5.
- lw x0 is in EX; ID reads rs1 = 0.
  - Required: stall = 0 (x0 exemption).
- flush = 1 and a load-use hazard occur in the same cycle.
  - Required: stall = 0 and ex_ctrl = 0 next cycle.
- Halt opcode is issued with DRAIN_CYCLES = 3.
  - Required: stall = 1 from the load edge, halted = 1 exactly 3 edges later, and it stays high while id_* toggles.
  - The same halt with flush asserted must stay in RUN with halted = 0.
- reset_n pulses low mid-DRAIN, asynchronously between edges.
  - Required: ex_ctrl = 0, halted = 0 and stall = 0 immediately, with no clock edge needed.
